// File: rtl/fir_line_buffer.sv
// rtl/fir_line_buffer.sv - four-line buffer feeding 5-row pixel columns to a 5x5 FIR
// Raster pixels in, one vertical 5-pixel column out per STREAM pixel, one cycle later.
module fir_line_buffer #(
  parameter int IMG_WIDTH  = 8,
  parameter int IMG_HEIGHT = 6
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  input  logic       in_sof,
  input  logic [7:0] in_pixel,
  output logic [7:0] pixel0,
  output logic [7:0] pixel1,
  output logic [7:0] pixel2,
  output logic [7:0] pixel3,
  output logic [7:0] pixel4,
  output logic       out_valid,
  output logic       out_sol,
  output logic       out_eof
);

  localparam int CW = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
  localparam int RW = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);
  localparam logic [RW-1:0] ROW_FILL_LAST = RW'(3);

  typedef enum logic [1:0] {IDLE, FILL, STREAM} state_t;

  state_t        state;
  logic [CW-1:0] col;
  logic [RW-1:0] row;

  logic [7:0] lb0 [IMG_WIDTH];
  logic [7:0] lb1 [IMG_WIDTH];
  logic [7:0] lb2 [IMG_WIDTH];
  logic [7:0] lb3 [IMG_WIDTH];

  logic          accept;
  logic          streaming;
  logic          col_last;
  logic          row_last;
  logic [CW-1:0] c;
  logic [RW-1:0] r;

  // A start-of-frame pixel always lands at row 0 col 0, whatever the counters say.
  always_comb begin
    accept    = in_valid && (in_sof || (state != IDLE));
    c         = in_sof ? '0 : col;
    r         = in_sof ? '0 : row;
    col_last  = (c == COL_LAST);
    row_last  = (r == ROW_LAST);
    streaming = accept && !in_sof && (state == STREAM);
  end

  // Line memories shift vertically at the current column; contents are never reset.
  always_ff @(posedge clk) begin
    if (accept) begin
      lb0[c] <= in_pixel;
      lb1[c] <= lb0[c];
      lb2[c] <= lb1[c];
      lb3[c] <= lb2[c];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      col       <= '0;
      row       <= '0;
      pixel0    <= '0;
      pixel1    <= '0;
      pixel2    <= '0;
      pixel3    <= '0;
      pixel4    <= '0;
      out_valid <= 1'b0;
      out_sol   <= 1'b0;
      out_eof   <= 1'b0;
    end else begin
      out_valid <= streaming;
      out_sol   <= streaming && (c == '0);
      out_eof   <= streaming && col_last && row_last;
      if (streaming) begin
        pixel4 <= in_pixel;
        pixel3 <= lb0[c];
        pixel2 <= lb1[c];
        pixel1 <= lb2[c];
        pixel0 <= lb3[c];
      end
      if (accept) begin
        if (col_last) begin
          col <= '0;
          row <= r + 1'b1;
        end else begin
          col <= c + 1'b1;
          row <= r;
        end
        if (in_sof) begin
          state <= FILL;
        end else begin
          case (state)
            FILL: begin
              if (col_last && (r == ROW_FILL_LAST)) state <= STREAM;
            end
            STREAM: begin
              if (col_last && row_last) begin
                state <= IDLE;
                col   <= '0;
                row   <= '0;
              end
            end
            default: ;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_fir_line_buffer.sv
// tb/tb_fir_line_buffer.sv - scoreboard bench for fir_line_buffer
// Stimulus pushes hand-derived columns; an independent monitor pops and compares.
module tb_fir_line_buffer;
  localparam int W = 8;
  localparam int H = 6;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_sof = 1'b0;
  logic [7:0] in_pixel = 8'h00;
  logic [7:0] pixel0, pixel1, pixel2, pixel3, pixel4;
  logic       out_valid, out_sol, out_eof;

  fir_line_buffer #(.IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_sof(in_sof), .in_pixel(in_pixel),
    .pixel0(pixel0), .pixel1(pixel1), .pixel2(pixel2), .pixel3(pixel3), .pixel4(pixel4),
    .out_valid(out_valid), .out_sol(out_sol), .out_eof(out_eof)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] p0, p1, p2, p3, p4;
    logic       sol, eof;
  } col_t;

  col_t exp_q[$];
  int   n_vec = 0;
  int   n_miss = 0;
  int   pulses = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every presented column must match the oldest pending expectation.
  always @(negedge clk) begin
    col_t e;
    if (rst && out_valid) begin
      pulses++;
      if (exp_q.size() == 0) begin
        n_vec++;
        n_miss++;
        $display("FAIL unexpected_column: got out_valid=1 (%h %h %h %h %h), expected none",
                 pixel0, pixel1, pixel2, pixel3, pixel4);
      end else begin
        e = exp_q.pop_front();
        check("column", {22'd0, pixel0, pixel1, pixel2, pixel3, pixel4, out_sol, out_eof}, {22'd0, e});
      end
    end
  end

  task automatic drive(input logic v, input logic s, input logic [7:0] p);
    in_valid = v;
    in_sof   = s;
    in_pixel = p;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_sof   = 1'b0;
  endtask

  // Pixel value is row*16+col+k; rows >= 4 yield the column rows r-4..r.
  task automatic send_frame(input int k, input bit sof, input bit expect_out, input int n_pix, input bit gap);
    col_t e;
    for (int i = 0; i < n_pix; i++) begin
      int r = i / W;
      int c = i % W;
      if (expect_out && r >= 4) begin
        e.p0  = 8'((r - 4) * 16 + c + k);
        e.p1  = 8'((r - 3) * 16 + c + k);
        e.p2  = 8'((r - 2) * 16 + c + k);
        e.p3  = 8'((r - 1) * 16 + c + k);
        e.p4  = 8'(r * 16 + c + k);
        e.sol = (c == 0);
        e.eof = (r == H - 1) && (c == W - 1);
        exp_q.push_back(e);
      end
      drive(1'b1, sof && (i == 0), 8'(r * 16 + c + k));
      if (gap && r == 4 && c == 2) begin
        for (int g = 0; g < 3; g++) begin
          drive(1'b0, 1'b0, 8'hEE);
          check("gap_valid", {63'd0, out_valid}, 64'd0);
          check("gap_flags", {62'd0, out_sol, out_eof}, 64'd0);
          check("gap_hold", {24'd0, pixel0, pixel1, pixel2, pixel3, pixel4}, 64'h02_12_22_32_42);
        end
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 8'h00);
  endtask

  initial begin
    int p;
    #12;
    check("reset_outputs", {22'd0, pixel0, pixel1, pixel2, pixel3, pixel4, out_sol, out_eof}, 64'd0);
    check("reset_valid", {63'd0, out_valid}, 64'd0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;

    // Pixels before any start-of-frame are ignored.
    p = pulses;
    send_frame(0, 1'b0, 1'b0, 10, 1'b0);
    idle(2);
    check("pre_sof_pulses", 64'(pulses - p), 64'd0);

    // Full frame, then trailing pixels without in_sof.
    p = pulses;
    send_frame(0, 1'b1, 1'b1, W * H, 1'b0);
    idle(2);
    check("frame1_pulses", 64'(pulses - p), 64'd16);
    p = pulses;
    send_frame(0, 1'b0, 1'b0, 12, 1'b0);
    idle(2);
    check("post_eof_pulses", 64'(pulses - p), 64'd0);

    // Frame with a three-cycle stall after 0x42.
    p = pulses;
    send_frame(0, 1'b1, 1'b1, W * H, 1'b1);
    idle(2);
    check("gap_frame_pulses", 64'(pulses - p), 64'd16);

    // Reset in the middle of row 4.
    send_frame(0, 1'b1, 1'b1, 4 * W + 4, 1'b0);
    @(negedge clk);
    #1;
    rst = 1'b0;
    #1;
    check("async_reset_outputs", {22'd0, pixel0, pixel1, pixel2, pixel3, pixel4, out_sol, out_eof}, 64'd0);
    check("async_reset_valid", {63'd0, out_valid}, 64'd0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    p = pulses;
    send_frame(0, 1'b0, 1'b0, W * H, 1'b0);
    idle(2);
    check("after_reset_pulses", 64'(pulses - p), 64'd0);

    // Restart mid row 2, then a full frame with values +1.
    send_frame(0, 1'b1, 1'b0, 2 * W + 4, 1'b0);
    p = pulses;
    send_frame(1, 1'b1, 1'b1, W * H, 1'b0);
    idle(2);
    check("restart_pulses", 64'(pulses - p), 64'd16);

    // Back-to-back frames.
    p = pulses;
    send_frame(0, 1'b1, 1'b1, W * H, 1'b0);
    send_frame(0, 1'b1, 1'b1, W * H, 1'b0);
    idle(2);
    check("b2b_pulses", 64'(pulses - p), 64'd32);

    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule

// File: doc/fir_line_buffer.md
FIR_LINE_BUFFER -- requirements
Module: fir_line_buffer

Interface
REQ-001 SHALL have parameter IMG_WIDTH, default 8, pixels per line (>= 5).
REQ-002 SHALL have parameter IMG_HEIGHT, default 6, lines per frame (>= 5).
REQ-003 One clock; reset is asynchronous and active-low.
REQ-004 SHALL have port clk  input  1  rising-edge clock.
REQ-005 SHALL have port rst  input  1  asynchronous active-low reset.
REQ-006 SHALL have port in_valid  input  1  in_pixel/in_sof qualifier.
REQ-007 SHALL have port in_sof  input  1  marks first pixel (row 0, col 0) of a frame.
REQ-008 SHALL have port in_pixel  input  8  raster-order pixel, unsigned.
REQ-009 SHALL have ports pixel0..pixel4  output  8 each  vertical column for the 5x5 FIR: pixel0 = row y-4, pixel4 = row y, same column.
REQ-010 SHALL have port out_valid  output  1  column valid; drives the FIR in_valid.
REQ-011 SHALL have port out_sol  output  1  column is col 0 of its line.
REQ-012 SHALL have port out_eof  output  1  column is last column of last line.

Function
REQ-013 SHALL hold 4 line memories LB0..LB3, each IMG_WIDTH x 8 bit; LB0 = row y-1 ... LB3 = row y-4; contents not reset.
REQ-014 SHALL keep col counter 0..IMG_WIDTH-1 and row counter 0..IMG_HEIGHT-1.
REQ-015 SHALL implement FSM states IDLE, FILL, STREAM; reset state IDLE.
REQ-016 IDLE: accepted pixels without in_sof SHALL be ignored (no memory write, no counter change).
REQ-017 Any cycle with in_valid=1 and in_sof=1 SHALL, in any state, treat the pixel as row 0 col 0 and go to FILL (restart mid-frame allowed).
REQ-018 Each accepted pixel at col c (FILL/STREAM or sof) SHALL write LB0[c]=in_pixel, LBk[c]=old LB(k-1)[c] for k=1..3.
REQ-019 Col SHALL increment per accepted pixel, wrap IMG_WIDTH-1 -> 0 and increment row on wrap.
REQ-020 FILL -> STREAM when row advances from 3 to 4.
REQ-021 STREAM, pixel at col IMG_WIDTH-1 of row IMG_HEIGHT-1 -> IDLE, counters cleared.
REQ-022 Latency 1 cycle: for an accepted STREAM pixel at col c, next cycle pixel4=in_pixel, pixel3=old LB0[c], pixel2=old LB1[c], pixel1=old LB2[c], pixel0=old LB3[c], out_valid=1.
REQ-023 out_sol=1 with out_valid when c=0; out_eof=1 with out_valid for the REQ-021 pixel; both 0 otherwise.
REQ-024 in_valid=0 cycle SHALL produce out_valid=0, out_sol=0, out_eof=0 next cycle; pixel0..4 hold previous values; no state/counter/memory change.
REQ-025 FILL pixels SHALL produce out_valid=0; exactly (IMG_HEIGHT-4)*IMG_WIDTH out_valid pulses per complete frame.
REQ-026 No backpressure; downstream SHALL accept every out_valid column.

Reset
REQ-027 rst=0 SHALL asynchronously force state IDLE, col=0, row=0, pixel0..4=0, out_valid=0, out_sol=0, out_eof=0.
REQ-028 Reset mid-frame SHALL discard the frame; after release, pixels ignored until in_sof.

Verification (IMG_WIDTH=8, IMG_HEIGHT=6, pixel = row*16+col)
REQ-029 Full frame, in_valid continuous -> no out_valid during rows 0-3; input 0x40 (row 4 col 0) -> next cycle pixel0..4 = 0x00,0x10,0x20,0x30,0x40, out_valid=1, out_sol=1; 16 out_valid total.
REQ-030 Last pixel 0x57 -> next cycle pixel0..4 = 0x17,0x27,0x37,0x47,0x57, out_valid=1, out_eof=1; following pixels without in_sof -> out_valid stays 0.
REQ-031 in_valid=0 for 3 cycles between 0x42 and 0x43 -> out_valid=0 those cycles, pixels hold 0x02..0x42; 0x43 column then 0x03,0x13,0x23,0x33,0x43.
REQ-032 rst=0 asserted mid row 4 -> outputs 0 immediately, before next clk; after release, frame without leading in_sof -> no out_valid.
REQ-033 in_sof mid row 2 then full frame with values +1 -> first out_valid column = 0x01,0x11,0x21,0x31,0x41.
REQ-034 Back-to-back frames (second in_sof right after 0x57) -> second frame output identical to first, 16 pulses.
